// File: rtl/fft_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_serializer_if
//   Bundles the frame-capture side and the beat-streaming side of the FFT
//   output unloader.
//
//   Capture side : in_valid, in_ready, in_real[16*W], in_im[16*W]
//                  (bin n occupies bits [W*n+W-1 : W*n])
//   Stream side  : out_valid, out_ready, out_real[W], out_im[W],
//                  out_index[4], out_last
//   Status       : overrun (sticky, cleared only by reset)
//
//   slave  : the serializer's view
//   master : the view of whatever drives frames in and consumes beats
// ---------------------------------------------------------------------------
interface fft_frame_serializer_if #(
  parameter int W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [16*W-1:0] in_real;
  logic [16*W-1:0] in_im;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_real;
  logic [W-1:0]    out_im;
  logic [3:0]      out_index;
  logic            out_last;
  logic            overrun;

  modport slave (
    input  in_valid, in_real, in_im, out_ready,
    output in_ready, out_valid, out_real, out_im, out_index, out_last, overrun
  );

  modport master (
    output in_valid, in_real, in_im, out_ready,
    input  in_ready, out_valid, out_real, out_im, out_index, out_last, overrun
  );
endinterface

// File: rtl/fft_frame_serializer.sv
// ---------------------------------------------------------------------------
// fft_frame_serializer
//   Output unloader for the 16-point FFT. A whole 16-bin complex frame is
//   captured in one cycle into one of two banks (ping-pong), then streamed
//   out one bin per beat over valid/ready. With REORDER=1 beat k carries
//   bin bitrev4(k), turning the FFT's bit-reversed output into natural order.
//
//   Parameters : REORDER (1 = bit-reverse read address), W (component width)
//   Ports      : clk  - rising-edge clock
//                rst  - asynchronous, active-high reset
//                bus  - fft_frame_serializer_if.slave (capture side,
//                       stream side, sticky overrun)
// ---------------------------------------------------------------------------
module fft_frame_serializer #(
  parameter bit REORDER = 1'b1,
  parameter int W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  fft_frame_serializer_if.slave         bus
);

  function automatic logic [3:0] bitrev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // Bank storage: [bank][bin]
  logic signed [W-1:0] re_q [2][16];
  logic signed [W-1:0] re_d [2][16];
  logic signed [W-1:0] im_q [2][16];
  logic signed [W-1:0] im_d [2][16];

  logic [1:0] count_q,   count_d;    // banks holding frames, 0..2
  logic [3:0] beat_q,    beat_d;     // read counter within the frame
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       overrun_q, overrun_d;

  logic       in_ready;
  logic       out_valid;
  logic       cap;
  logic       fire;
  logic       last_fire;
  logic [3:0] rd_addr;

  // in_ready depends on registered state only, so the full case does not
  // open up when the last beat of a frame is being accepted this cycle.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign cap       = bus.in_valid && in_ready;
  assign fire      = out_valid && bus.out_ready;
  assign last_fire = fire && (beat_q == 4'd15);
  assign rd_addr   = REORDER ? bitrev4(beat_q) : beat_q;

  // Next-state: control
  always_comb begin
    count_d   = count_q;
    beat_d    = beat_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    overrun_d = overrun_q;

    unique case ({cap, last_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Beat counter wraps naturally from 15 to 0.
    if (fire)      beat_d    = beat_q + 4'd1;
    if (last_fire) rd_bank_d = ~rd_bank_q;
    if (cap)       wr_bank_d = ~wr_bank_q;

    // A frame offered while full is lost: the FFT pipeline cannot stall.
    if (bus.in_valid && !in_ready) overrun_d = 1'b1;
  end

  // Next-state: bank storage. When count_q is 1 the write bank is always
  // the idle one, so the draining bank is never overwritten.
  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (cap) begin
      for (int n = 0; n < 16; n++) begin
        re_d[wr_bank_q][n] = bus.in_real[W*n +: W];
        im_d[wr_bank_q][n] = bus.in_im[W*n +: W];
      end
    end
  end

  // Registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      beat_q    <= 4'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < 16; n++) begin
          re_q[b][n] <= '0;
          im_q[b][n] <= '0;
        end
      end
    end else begin
      count_q   <= count_d;
      beat_q    <= beat_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      overrun_q <= overrun_d;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

  // Output mux: zeros whenever no beat is presented.
  always_comb begin
    bus.out_real  = '0;
    bus.out_im    = '0;
    bus.out_index = 4'd0;
    bus.out_last  = 1'b0;
    if (out_valid) begin
      bus.out_real  = re_q[rd_bank_q][rd_addr];
      bus.out_im    = im_q[rd_bank_q][rd_addr];
      bus.out_index = beat_q;
      bus.out_last  = (beat_q == 4'd15);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_serializer
//   Drives two serializers (REORDER=0 and REORDER=1) with identical stimulus
//   and compares both against a frame-queue reference model.
// ---------------------------------------------------------------------------
module tb_fft_frame_serializer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b1;
  logic [16*W-1:0] in_real_v = '0;
  logic [16*W-1:0] in_im_v   = '0;

  fft_frame_serializer_if #(.W(W)) bus0 ();
  fft_frame_serializer_if #(.W(W)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_real   = in_real_v;
  assign bus0.in_im     = in_im_v;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_real   = in_real_v;
  assign bus1.in_im     = in_im_v;
  assign bus1.out_ready = out_ready;

  fft_frame_serializer #(.REORDER(1'b0), .W(W)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fft_frame_serializer #(.REORDER(1'b1), .W(W)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int passes = 0;

  logic [79:0] dut_vec;
  assign dut_vec = {bus0.in_ready, bus0.overrun, bus0.out_valid, bus0.out_index, bus0.out_last,
                    bus0.out_real, bus0.out_im,
                    bus1.in_ready, bus1.overrun, bus1.out_valid, bus1.out_index, bus1.out_last,
                    bus1.out_real, bus1.out_im};

  // ---------------- reference model: a FIFO of whole frames ----------------
  typedef struct packed {
    logic [16*W-1:0] re;
    logic [16*W-1:0] im;
  } frame_t;

  frame_t fq[$];
  int     mk;
  bit     movr;
  int     m_sz;
  bit     m_acc;
  bit     m_fire;
  frame_t m_f;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      mk   = 0;
      movr = 1'b0;
    end else begin
      m_sz   = fq.size();
      m_acc  = in_valid && (m_sz < 2);
      m_fire = (m_sz > 0) && out_ready;
      if (in_valid && !m_acc) movr = 1'b1;
      if (m_fire) begin
        mk++;
        if (mk == 16) begin
          mk = 0;
          void'(fq.pop_front());
        end
      end
      if (m_acc) begin
        m_f.re = in_real_v;
        m_f.im = in_im_v;
        fq.push_back(m_f);
      end
    end
  end

  function automatic logic [79:0] exp_vec();
    logic [W-1:0] r0, i0, r1, i1;
    logic [7:0]   hs;
    logic         v;
    int           rv;
    r0 = '0; i0 = '0; r1 = '0; i1 = '0;
    v  = (fq.size() > 0);
    hs = {(fq.size() < 2), movr, 6'd0};
    if (v) begin
      rv = (mk % 2) * 8 + ((mk / 2) % 2) * 4 + ((mk / 4) % 2) * 2 + (mk / 8) % 2;
      r0 = fq[0].re[W*mk +: W];
      i0 = fq[0].im[W*mk +: W];
      r1 = fq[0].re[W*rv +: W];
      i1 = fq[0].im[W*rv +: W];
      hs = {(fq.size() < 2), movr, 1'b1, 4'(mk), (mk == 15)};
    end
    return {hs, r0, i0, hs, r1, i1};
  endfunction

  task automatic load_ramp(input int base);
    for (int n = 0; n < 16; n++) begin
      in_real_v[W*n +: W] = W'(base + n);
      in_im_v[W*n +: W]   = W'(-n);
    end
  endtask

  task automatic load_random();
    for (int n = 0; n < 16; n++) begin
      in_real_v[W*n +: W] = W'($urandom);
      in_im_v[W*n +: W]   = W'($urandom);
    end
  endtask

  // ------------------------------- tests ----------------------------------
  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_during got=%h exp=%h", dut_vec, exp_vec());
    else passes++;
    checks++;
    if ({bus0.in_ready, bus0.out_valid, bus0.overrun, bus1.in_ready, bus1.out_valid, bus1.overrun} !== 6'b100100)
      $display("FAIL reset_flags got=%b%b%b exp=100", bus0.in_ready, bus0.out_valid, bus0.overrun);
    else passes++;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus0.in_ready, bus0.out_valid, bus0.overrun} !== 3'b100)
      $display("FAIL reset_release got=%b%b%b exp=100", bus0.in_ready, bus0.out_valid, bus0.overrun);
    else passes++;
    checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_release_vec got=%h exp=%h", dut_vec, exp_vec());
    else passes++;
  endtask

  task automatic test_natural_order();
    int nb;
    nb = 0;
    out_ready = 1'b1;
    load_ramp(0);
    in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL natural i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else passes++;
      if (bus0.out_valid) begin
        checks++;
        if ({bus0.out_real, bus0.out_im, bus0.out_index, bus0.out_last} !== {W'(nb), W'(-nb), 4'(nb), (nb == 15)})
          $display("FAIL natural_beat k=%0d got re=%0d idx=%0d last=%b exp re=%0d", nb, bus0.out_real,
                   bus0.out_index, bus0.out_last, nb);
        else passes++;
        nb++;
      end
    end
    checks++;
    if (nb !== 16) $display("FAIL natural_count got=%0d exp=16", nb);
    else passes++;
  endtask

  task automatic test_bit_reversed();
    int rev_tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int nb;
    nb = 0;
    out_ready = 1'b1;
    load_ramp(0);
    in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL bitrev i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else passes++;
      if (bus1.out_valid && nb < 16) begin
        checks++;
        if ({bus1.out_real, bus1.out_index} !== {W'(rev_tbl[nb]), 4'(nb)})
          $display("FAIL bitrev_beat k=%0d got re=%0d idx=%0d exp re=%0d", nb, bus1.out_real, bus1.out_index,
                   rev_tbl[nb]);
        else passes++;
        nb++;
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    bit prev_stall;
    logic [W+4-1:0] saved;
    acc = 0;
    prev_stall = 1'b0;
    saved = '0;
    load_random();
    in_valid = 1'b1;
    for (int c = 0; c < 80 && acc < 16; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL backpressure c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      else passes++;
      if (prev_stall) begin
        checks++;
        if ({bus0.out_real, bus0.out_index} !== saved)
          $display("FAIL backpressure_hold c=%0d got=%h exp=%h", c, {bus0.out_real, bus0.out_index}, saved);
        else passes++;
      end
      out_ready  = (c % 4 == 0) || (c % 4 == 3);
      prev_stall = bus0.out_valid && !out_ready;
      saved      = {bus0.out_real, bus0.out_index};
      if (bus0.out_valid && out_ready) acc++;
    end
    checks++;
    if (acc !== 16) $display("FAIL backpressure_beats got=%0d exp=16", acc);
    else passes++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) $display("FAIL backpressure_done got=%b exp=0", bus0.out_valid);
    else passes++;
  endtask

  task automatic test_ping_pong();
    out_ready = 1'b1;
    load_ramp(100);
    in_valid = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL pingpong i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else passes++;
      checks++;
      if (bus0.out_valid !== (i < 32)) $display("FAIL pingpong_valid i=%0d got=%b exp=%b", i, bus0.out_valid, (i < 32));
      else passes++;
      if (i < 32) begin
        checks++;
        if (bus0.out_real !== W'(i < 16 ? 100 + i : 200 + i - 16))
          $display("FAIL pingpong_data i=%0d got=%0d exp=%0d", i, bus0.out_real, (i < 16 ? 100 + i : 184 + i));
        else passes++;
      end
      if (i == 0) begin
        checks++;
        if (bus0.in_ready !== 1'b1) $display("FAIL pingpong_ready_b got=%b exp=1", bus0.in_ready);
        else passes++;
        load_ramp(200);
      end else if (i == 1) begin
        checks++;
        if (bus0.in_ready !== 1'b0) $display("FAIL pingpong_full got=%b exp=0", bus0.in_ready);
        else passes++;
        load_ramp(300);
      end else if (i == 2) begin
        in_valid = 1'b0;
        checks++;
        if ({bus0.overrun, bus1.overrun} !== 2'b11) $display("FAIL pingpong_overrun got=%b exp=11", {bus0.overrun, bus1.overrun});
        else passes++;
      end else if (i == 15 || i == 16) begin
        checks++;
        if (bus0.in_ready !== (i == 16)) $display("FAIL pingpong_ready_return i=%0d got=%b exp=%b", i, bus0.in_ready, (i == 16));
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    load_random();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL middrain i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else passes++;
    end
    checks++;
    if (bus0.out_index !== 4'd7) $display("FAIL middrain_beat7 got=%0d exp=7", bus0.out_index);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus0.out_valid, bus1.out_valid, bus0.overrun} !== 3'b000)
      $display("FAIL middrain_reset got=%b%b%b exp=000", bus0.out_valid, bus1.out_valid, bus0.overrun);
    else passes++;
    checks++;
    if (dut_vec !== exp_vec()) $display("FAIL middrain_reset_vec got=%h exp=%h", dut_vec, exp_vec());
    else passes++;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    load_ramp(50);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL afterreset i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      else passes++;
      if (i < 16) begin
        checks++;
        if ({bus0.out_valid, bus0.out_real, bus0.out_index} !== {1'b1, W'(50 + i), 4'(i)})
          $display("FAIL afterreset_beat i=%0d got re=%0d idx=%0d exp re=%0d idx=%0d", i, bus0.out_real,
                   bus0.out_index, 50 + i, i);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      else passes++;
      in_valid  = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid) load_random();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_natural_order();
    test_bit_reversed();
    test_backpressure();
    test_ping_pong();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Output unloader for the 16-point FFT pipeline. It captures one complete 16-bin complex frame from the final registered stage in a single cycle and streams the bins out one per cycle over a valid/ready interface, optionally reordering them from bit-reversed to natural index order. A two-frame ping-pong buffer lets a new frame land while the previous one is still draining.

## Interface
- `REORDER`, default 1. When 1, output beat k carries captured bin bitrev4(k). When 0, beat k carries bin k.
- `W`, default 16. Width of each real and imaginary component, two's complement, passed through unchanged.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a frame is present on `in_real`/`in_im` this cycle.
- `in_ready` out 1: a frame can be accepted this cycle.
- `in_real` in 16*W: bin n real component at bits [W*n+W-1 : W*n], n = 0..15.
- `in_im` in 16*W: bin n imaginary component, same packing as `in_real`.
- `out_valid` out 1: an output beat is presented.
- `out_ready` in 1: the downstream consumer accepts the beat.
- `out_real` out W: real component of the current bin.
- `out_im` out W: imaginary component of the current bin.
- `out_index` out 4: natural-order bin number of the current beat, equal to the beat counter k.
- `out_last` out 1: high on beat k = 15.
- `overrun` out 1: sticky flag. Set when `in_valid` is high and `in_ready` is low. Cleared only by `rst`.

## Operation
- Storage: two banks, each holding 16 × (real, imag) registers. Control state:
  - `wr_bank`: bank the next frame is written into.
  - `rd_bank`: bank currently being read.
  - `count`: number of banks holding frames, 0..2.
  - `beat`: 4-bit read counter.
- In-side rules:
  - `in_ready` = (`count` < 2). It is purely a function of registered state, with no combinational path from `out_ready`.
  - Capture happens when `in_valid` && `in_ready`. All 16 bins are written into `wr_bank` in that one cycle, then `wr_bank` toggles.
- Out-side rules:
  - `out_valid` = (`count` > 0).
  - Data is muxed from `rd_bank` at address `REORDER ? bitrev4(beat) : beat`. bitrev4(b3 b2 b1 b0) = b0 b1 b2 b3.
  - While `out_valid` = 0, `out_real`, `out_im`, `out_index` and `out_last` are driven to 0.
- Beat handshake: a beat transfers on `out_valid` && `out_ready`, and `beat` increments. When a beat transfers with `beat` = 15:
  - `beat` wraps to 0;
  - `rd_bank` toggles;
  - `count` decrements.
- Simultaneous events:
  - Capture and a final-beat transfer in the same cycle leave `count` unchanged, and both bank pointers toggle.
  - Capture with `count` = 1 while the other bank is draining is legal. The bank being read is never written.
- Full condition: when `count` = 2, `in_ready` stays low even if the last beat is being accepted that same cycle. There is no bypass; the freed slot becomes visible on the next cycle.
- Overrun: the FFT pipeline cannot stall, so an offered frame that is not accepted is discarded. Storage is not modified, and `overrun` is set on the next edge.
- Backpressure: while `out_ready` is low, `beat` and the output data hold steady. Output data is stable while `out_valid` && !`out_ready`.
- Reset, mid-frame or otherwise: takes effect immediately and asynchronously.
  - `count`, `beat`, `wr_bank`, `rd_bank` and `overrun` go to 0.
  - All bank registers go to 0.
  - Any partially drained frame is discarded.

## Timing
- Latency: a frame captured at edge N gives `out_valid` = 1 in the cycle after edge N (when `count` was 0). It presents beat 0 in that cycle.
- Throughput: one beat per cycle while `out_ready` stays high, so 16 cycles per frame. Sustained input is limited to one frame per 16 cycles. Back-to-back frames drain with no bubble between beat 15 and the next beat 0.
- After reset release:
  - `in_ready` = 1 in the first cycle;
  - `out_valid` = 0;
  - `overrun` = 0.
- Two frames captured on consecutive cycles:
  - `in_ready` = 0 from the second cycle onward;
  - `in_ready` returns to 1 in the cycle after beat 15 of the first frame transfers.

## Test plan
- Reset: assert `rst` asynchronously between edges, with `in_valid` = 0 and `out_ready` = 1.
  - During reset: `in_ready` = 1, `out_valid` = 0, all outputs 0, `overrun` = 0.
  - After release: `in_ready` = 1, `out_valid` = 0, `overrun` = 0.
- Natural order: `REORDER` = 0, one frame with bin n real = n, imag = -n, `out_ready` held at 1.
  - 16 consecutive beats: real 0..15, imag 0,-1..-15, `out_index` 0..15.
  - `out_last` only on beat 15; `out_valid` drops the following cycle.
- Bit-reversed: `REORDER` = 1, same frame.
  - Real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - `out_index` 0..15.
- Backpressure: toggle `out_ready` 1,0,0,1,...
  - Data and `out_index` hold while stalled; no beat is lost or duplicated.
  - The frame completes after 16 accepted beats.
- Ping-pong and full: frames A (real = 100+n) and B (real = 200+n) captured on consecutive cycles, then frame C offered on the third cycle.
  - `in_ready` = 0 and C is dropped; `overrun` = 1 next cycle.
  - A drains (100..115), then B (200..215) with no gap.
  - `in_ready` returns to 1 after A's last beat.
- Reset mid-drain: assert `rst` during beat 7 of a frame.
  - `out_valid` = 0 immediately.
  - After release, a new frame (real = 50+n) streams from beat 0 with `out_index` = 0.
